// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the debounced multi-input gate.
//   - 3-bit gate function encodings (mode input / mode_q register)
//   - result driven for the reserved mode codes
package gate_pkg;

   typedef enum logic [2:0] {
      MODE_AND  = 3'b000,
      MODE_OR   = 3'b001,
      MODE_XOR  = 3'b010,
      MODE_NAND = 3'b011,
      MODE_NOR  = 3'b100,
      MODE_XNOR = 3'b101
   } gate_mode_e;

   localparam logic [2:0] MODE_RESET        = MODE_AND;
   localparam logic       GATE_RSVD_RESULT  = 1'b0;

endpackage

// File: rtl/input_debounce.sv
// input_debounce: one channel of pin conditioning.
//   clk     in   system clock
//   rst_n   in   async active-low reset
//   in      in   raw asynchronous pin level
//   db_out  out  accepted (debounced) level
// A 2-flop synchroniser feeds a counter that must see the synchronised
// level differ from the accepted level for DB_CYCLES consecutive edges
// before the new level is taken.
module input_debounce
   import gate_pkg::*;
#(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic db_out
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic             s1_q;
   logic             s2_q;
   logic             db_q;
   logic             db_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // A bounce back to the accepted level clears the count, so only an
   // unbroken run of DB_CYCLES differing samples is accepted.
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (s2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         db_d  = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= in;
         s2_q  <= s1_q;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign db_out = db_q;

endmodule

// File: rtl/multi_gate_debounced.sv
// multi_gate_debounced: N_IN debounced pin inputs combined by a
// run-time selectable reduction gate with a registered result.
//   clk       in   system clock
//   rst_n     in   async active-low reset
//   in        in   [N_IN] raw asynchronous pin levels
//   mode      in   [3]    gate function select (quasi-static)
//   db_out    out  [N_IN] debounced input vector
//   c         out  registered gate result
//   c_toggle  out  one-cycle pulse in the cycle c takes a new value
module multi_gate_debounced
   import gate_pkg::*;
#(
   parameter int N_IN      = 2,
   parameter int DB_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] in,
   input  logic [2:0]      mode,
   output logic [N_IN-1:0] db_out,
   output logic            c,
   output logic            c_toggle
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);

   logic [N_IN-1:0] db_vec;
   logic [2:0]      mode_q;
   logic            gate_d;
   logic            c_q;
   logic            c_toggle_q;
   logic            c_toggle_d;

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_ch
      input_debounce #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .in     (in[gi]),
         .db_out (db_vec[gi])
      );
   end

   always_comb begin
      gate_d = GATE_RSVD_RESULT;
      case (mode_q)
         MODE_AND:  gate_d =  (&db_vec);
         MODE_OR:   gate_d =  (|db_vec);
         MODE_XOR:  gate_d =  (^db_vec);
         MODE_NAND: gate_d = ~(&db_vec);
         MODE_NOR:  gate_d = ~(|db_vec);
         MODE_XNOR: gate_d = ~(^db_vec);
         default:   gate_d = GATE_RSVD_RESULT;
      endcase
   end

   assign c_toggle_d = (gate_d != c_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= MODE_RESET;
         c_q        <= 1'b0;
         c_toggle_q <= 1'b0;
      end else begin
         mode_q     <= mode;
         c_q        <= gate_d;
         c_toggle_q <= c_toggle_d;
      end
   end

   assign db_out   = db_vec;
   assign c        = c_q;
   assign c_toggle = c_toggle_q;

endmodule

// File: tb/tb_multi_gate_debounced.sv
module tb_multi_gate_debounced;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] in_a = 2'b11;
   logic [2:0] mode_a = 3'b000;
   logic [1:0] db_a;
   logic       c_a;
   logic       tog_a;

   logic [4:0] in_b = 5'b00000;
   logic [2:0] mode_b = 3'b010;
   logic [4:0] db_b;
   logic       c_b;
   logic       tog_b;

   int total = 0;
   int bad = 0;
   int tog_cnt_a = 0;
   int tog_cnt_b = 0;

   always #5 clk = ~clk;

   multi_gate_debounced #(.N_IN(2), .DB_CYCLES(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in_a),
      .mode     (mode_a),
      .db_out   (db_a),
      .c        (c_a),
      .c_toggle (tog_a)
   );

   multi_gate_debounced #(.N_IN(5), .DB_CYCLES(1)) dut5 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in_b),
      .mode     (mode_b),
      .db_out   (db_b),
      .c        (c_b),
      .c_toggle (tog_b)
   );

   typedef struct {
      string      name;
      logic [2:0] mode;
      logic [1:0] in;
      int         hold;
      logic [1:0] db;
      logic       c;
      int         tog;
   } vec_t;

   vec_t vecs[10];

   // one clock edge, then sample 1 time unit later; counts c_toggle pulses
   task automatic tick();
      @(posedge clk);
      #1;
      if (tog_a) tog_cnt_a++;
      if (tog_b) tog_cnt_b++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic sweep_exp [8];
   logic prev_c;

   initial begin
      vecs[0] = '{"and_00",   3'b000, 2'b00, 10, 2'b00, 1'b0, 1};
      vecs[1] = '{"and_01",   3'b000, 2'b01, 10, 2'b01, 1'b0, 0};
      vecs[2] = '{"and_10",   3'b000, 2'b10, 10, 2'b10, 1'b0, 0};
      vecs[3] = '{"and_11",   3'b000, 2'b11, 10, 2'b11, 1'b1, 1};
      vecs[4] = '{"and_00b",  3'b000, 2'b00, 10, 2'b00, 1'b0, 1};
      vecs[5] = '{"xor_01",   3'b010, 2'b01, 10, 2'b01, 1'b1, 1};
      vecs[6] = '{"xnor_01",  3'b101, 2'b01, 10, 2'b01, 1'b0, 1};
      vecs[7] = '{"nand_11",  3'b011, 2'b11, 10, 2'b11, 1'b0, 2};
      vecs[8] = '{"nor_00",   3'b100, 2'b00, 10, 2'b00, 1'b1, 1};
      vecs[9] = '{"or_00",    3'b001, 2'b00, 10, 2'b00, 1'b0, 1};

      sweep_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      // reset held with inputs high
      ticks(3);
      check("rst_c", c_a, 1'b0);
      check("rst_tog", tog_a, 1'b0);
      check("rst_db", db_a, 2'b00);
      check("rst_c5", c_b, 1'b0);
      rst_n = 1'b1;
      tog_cnt_a = 0;
      ticks(5);
      check("rel_db_e4", db_a, 2'b00);
      tick();
      check("rel_db_e5", db_a, 2'b11);
      check("rel_c_e5", c_a, 1'b0);
      tick();
      check("rel_c_e6", c_a, 1'b1);
      check("rel_tog_e6", tog_a, 1'b1);
      tick();
      check("rel_tog_e7", tog_a, 1'b0);
      check("rel_togcnt", tog_cnt_a, 1);

      // table-driven truth table and mode vectors
      for (int v = 0; v < 10; v++) begin
         in_a = vecs[v].in;
         mode_a = vecs[v].mode;
         tog_cnt_a = 0;
         ticks(vecs[v].hold);
         check({vecs[v].name, "_db"}, db_a, vecs[v].db);
         check({vecs[v].name, "_c"}, c_a, vecs[v].c);
         check({vecs[v].name, "_tog"}, tog_cnt_a, vecs[v].tog);
      end

      // bounce rejection (mode OR, in=00, c=0): 3-cycle pulse
      tog_cnt_a = 0;
      in_a = 2'b01;
      ticks(3);
      in_a = 2'b00;
      ticks(10);
      check("bounce3_db", db_a, 2'b00);
      check("bounce3_c", c_a, 1'b0);
      check("bounce3_tog", tog_cnt_a, 0);

      // 4-cycle pulse is accepted
      in_a = 2'b01;
      ticks(4);
      in_a = 2'b00;
      tick();
      check("pulse4_db_e4", db_a, 2'b00);
      tick();
      check("pulse4_db_e5", db_a, 2'b01);
      tick();
      check("pulse4_c_e6", c_a, 1'b1);
      ticks(8);
      check("pulse4_db_back", db_a, 2'b00);
      check("pulse4_c_back", c_a, 1'b0);
      check("pulse4_tog", tog_cnt_a, 2);

      // mode sweep with in=10
      in_a = 2'b10;
      mode_a = 3'b000;
      ticks(10);
      check("sweep_pre_c", c_a, 1'b0);
      prev_c = c_a;
      for (int m = 0; m < 8; m++) begin
         mode_a = 3'(m);
         tick();
         check($sformatf("sweep%0d_e0", m), c_a, prev_c);
         tick();
         check($sformatf("sweep%0d_e1", m), c_a, sweep_exp[m]);
         check($sformatf("sweep%0d_tog", m), tog_a, (sweep_exp[m] != prev_c));
         prev_c = sweep_exp[m];
         ticks(3);
      end

      // asynchronous reset while a debounce count sits at 2
      mode_a = 3'b001;
      ticks(10);
      check("mid_pre_c", c_a, 1'b1);
      in_a = 2'b11;
      ticks(4);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_c", c_a, 1'b0);
      check("mid_rst_db", db_a, 2'b00);
      ticks(2);
      rst_n = 1'b1;
      tog_cnt_a = 0;
      ticks(5);
      check("mid_rel_db_e4", db_a, 2'b00);
      tick();
      check("mid_rel_db_e5", db_a, 2'b11);
      tick();
      check("mid_rel_c_e6", c_a, 1'b1);
      check("mid_rel_togcnt", tog_cnt_a, 1);

      // 5-input XOR, DB_CYCLES=1
      tog_cnt_b = 0;
      in_b = 5'b10110;
      tick();
      check("w5_c_e0", c_b, 1'b0);
      tick();
      check("w5_db_e1", db_b, 5'b00000);
      tick();
      check("w5_db_e2", db_b, 5'b10110);
      check("w5_c_e2", c_b, 1'b0);
      tick();
      check("w5_c_e3", c_b, 1'b1);
      check("w5_tog_e3", tog_b, 1'b1);
      ticks(3);
      check("w5_togcnt", tog_cnt_b, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
